// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: sequences the data-memory access for the instruction held in EX/MEM.
// It issues one request per load/store to a multi-cycle memory (busy/done handshake),
// stalls the pipeline until the access completes, and flags access errors
// (misaligned address, conflicting read+write, timeout). err_out is sticky until rst.
//
// Optional feature macro: MEM_STAGE_PERF_CNT_EN adds saturating counters
// acc_cnt (completed accesses) and stall_cnt (cycles with stall_out=1).
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   MemRead_in, MemWrite_in    load/store request from EX/MEM
//   halt_in                    halt in EX/MEM, suppresses the access
//   addr_in, wdata_in          effective address and store data
//   mem_stall, mem_done        memory busy / access complete
//   mem_rdata                  memory read data (valid with mem_done)
//   mem_en, mem_wr             request strobe (one cycle per access) and direction
//   mem_addr, mem_wdata        request address/data, zero when mem_en=0
//   rdata_out                  load data to MEM/WB
//   stall_out                  pipeline freeze
//   err_out                    sticky access error
//   acc_cnt, stall_cnt         performance counters (MEM_STAGE_PERF_CNT_EN only)
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead_in,
  input  logic             MemWrite_in,
  input  logic             halt_in,
  input  logic [15:0]      addr_in,
  input  logic [15:0]      wdata_in,
  input  logic             mem_stall,
  input  logic             mem_done,
  input  logic [15:0]      mem_rdata,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  output logic [15:0]      rdata_out,
  output logic             stall_out,
  output logic             err_out
`ifdef MEM_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StWait} state_e;

  state_e         state_q, state_d;
  logic           lat_wr_q, lat_wr_d;
  logic [15:0]    lat_addr_q, lat_addr_d;
  logic [15:0]    lat_wdata_q, lat_wdata_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [15:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

  logic           access, bad, good, tmo_hit;
  logic           issue, iss_wr;
  logic [15:0]    iss_addr, iss_wdata;
  logic           complete, cmp_rd, stall;
  logic [15:0]    rdata_c;

  always_comb begin
    state_d     = state_q;
    lat_wr_d    = lat_wr_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    issue       = 1'b0;
    iss_wr      = 1'b0;
    iss_addr    = '0;
    iss_wdata   = '0;
    complete    = 1'b0;
    cmp_rd      = 1'b0;
    stall       = 1'b0;
    rdata_c     = rdata_q;

    access  = (MemRead_in | MemWrite_in) & ~halt_in & ~err_q;
    bad     = access & (addr_in[0] | (MemRead_in & MemWrite_in));
    good    = access & ~bad;
    tmo_hit = (tmo_q == TmoLast);

    unique case (state_q)
      StIdle: begin
        if (bad) begin
          err_d = 1'b1;
        end else if (good) begin
          lat_wr_d    = MemWrite_in;
          lat_addr_d  = addr_in;
          lat_wdata_d = wdata_in;
          tmo_d       = '0;
          if (!mem_stall) begin
            issue     = 1'b1;
            iss_wr    = MemWrite_in;
            iss_addr  = addr_in;
            iss_wdata = wdata_in;
            if (mem_done) begin
              complete = 1'b1;
              cmp_rd   = MemRead_in;
            end else begin
              stall   = 1'b1;
              state_d = StWait;
            end
          end else begin
            stall   = 1'b1;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (!mem_stall && mem_done) begin
          // Issue and completion in the same cycle: no stall, straight back to idle.
          issue     = 1'b1;
          iss_wr    = lat_wr_q;
          iss_addr  = lat_addr_q;
          iss_wdata = lat_wdata_q;
          complete  = 1'b1;
          cmp_rd    = ~lat_wr_q;
          state_d   = StIdle;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          tmo_d = tmo_q + 1'b1;
          if (!mem_stall) begin
            issue     = 1'b1;
            iss_wr    = lat_wr_q;
            iss_addr  = lat_addr_q;
            iss_wdata = lat_wdata_q;
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        if (mem_done) begin
          complete = 1'b1;
          cmp_rd   = ~lat_wr_q;
          state_d  = StIdle;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (complete && cmp_rd) begin
      rdata_d = mem_rdata;
      rdata_c = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      lat_wr_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      tmo_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_wr_q    <= lat_wr_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Outputs are forced low while rst is held so a live EX/MEM request cannot
  // reach the memory combinationally during reset.
  assign mem_en    = issue & ~rst;
  assign mem_wr    = iss_wr & ~rst;
  assign mem_addr  = rst ? 16'h0 : iss_addr;
  assign mem_wdata = rst ? 16'h0 : iss_wdata;
  assign rdata_out = rst ? 16'h0 : rdata_c;
  assign stall_out = stall & ~rst;
  assign err_out   = err_q;

`ifdef MEM_STAGE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (complete && (acc_cnt != {CNT_W{1'b1}})) acc_cnt <= acc_cnt + 1'b1;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead_in = 1'b0, MemWrite_in = 1'b0, halt_in = 1'b0;
  logic [15:0] addr_in = '0, wdata_in = '0;
  logic        mem_stall = 1'b0, mem_done = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_en, mem_wr, stall_out, err_out;
  logic [15:0] mem_addr, mem_wdata, rdata_out;
`ifdef MEM_STAGE_PERF_CNT_EN
  logic [15:0] acc_cnt, stall_cnt;
`endif

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead_in (MemRead_in),
    .MemWrite_in(MemWrite_in),
    .halt_in    (halt_in),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .mem_stall  (mem_stall),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .rdata_out  (rdata_out),
    .stall_out  (stall_out),
    .err_out    (err_out)
`ifdef MEM_STAGE_PERF_CNT_EN
    ,
    .acc_cnt    (acc_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  typedef struct packed {
    logic        stall;
    logic        err;
    logic [15:0] rdata;
  } cyc_t;

  req_t req_q[$];
  cyc_t cyc_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_req(input logic wr, input logic [15:0] a, input logic [15:0] wd);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = wd;
    req_q.push_back(r);
  endtask

  // One pipeline cycle: drive inputs just after the edge, queue expected outputs.
  task automatic cyc(input logic rd, input logic wr, input logic hlt,
                     input logic [15:0] a, input logic [15:0] wd,
                     input logic ms, input logic md, input logic [15:0] rdat,
                     input logic es, input logic ee, input logic [15:0] er);
    cyc_t c;
    @(posedge clk);
    #1;
    MemRead_in = rd; MemWrite_in = wr; halt_in = hlt;
    addr_in = a; wdata_in = wd;
    mem_stall = ms; mem_done = md; mem_rdata = rdat;
    c.stall = es; c.err = ee; c.rdata = er;
    cyc_q.push_back(c);
  endtask

  task automatic idle_inputs();
    MemRead_in = 0; MemWrite_in = 0; halt_in = 0; addr_in = 0; wdata_in = 0;
    mem_stall = 0; mem_done = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: checks requests whenever mem_en is seen, and per-cycle expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) begin
        if (req_q.size() == 0) begin
          chk("unexpected_mem_en", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_wr", 32'(mem_wr), 32'(r.wr));
          chk("req_addr", 32'(mem_addr), 32'(r.addr));
          chk("req_wdata", 32'(mem_wdata), 32'(r.wdata));
        end
      end else begin
        chk("idle_req_zero", {15'h0, mem_wr, mem_addr}, 32'(0));
        chk("idle_wdata_zero", 32'(mem_wdata), 32'(0));
      end
      if (cyc_q.size() != 0) begin
        cyc_t c;
        c = cyc_q.pop_front();
        chk("stall_out", 32'(stall_out), 32'(c.stall));
        chk("err_out", 32'(err_out), 32'(c.err));
        chk("rdata_out", 32'(rdata_out), 32'(c.rdata));
      end
    end
  end

  initial begin
    // Reset state.
    #3;
    chk("rst_mem_en", 32'(mem_en), 32'(0));
    chk("rst_stall", 32'(stall_out), 32'(0));
    chk("rst_err", 32'(err_out), 32'(0));
    chk("rst_rdata", 32'(rdata_out), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Read with same-cycle done: zero stall.
    exp_req(1'b0, 16'h0010, 16'h0000);
    cyc(1, 0, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 16'hBEEF);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'hBEEF);

    // Write, done 3 cycles after issue.
    exp_req(1'b1, 16'h0020, 16'h1234);
    cyc(0, 1, 0, 16'h0020, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'hBEEF);
    cyc(0, 1, 0, 16'h0020, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'hBEEF);
    cyc(0, 1, 0, 16'h0020, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'hBEEF);
    cyc(0, 1, 0, 16'h0020, 16'h1234, 0, 1, 16'hDEAD, 0, 0, 16'hBEEF);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'hBEEF);
`ifdef MEM_STAGE_PERF_CNT_EN
    chk("acc_cnt", 32'(acc_cnt), 32'(2));
    chk("stall_cnt", 32'(stall_cnt), 32'(3));
`endif

    // Read held off by mem_stall; inputs change during HOLD and must be ignored.
    exp_req(1'b0, 16'h0010, 16'h0000);
    cyc(1, 0, 0, 16'h0010, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'hBEEF);
    cyc(1, 0, 0, 16'h0FFF, 16'h0FFF, 1, 0, 16'h0000, 1, 0, 16'hBEEF);
    cyc(1, 0, 0, 16'h0FFF, 16'h0FFF, 0, 0, 16'h0000, 1, 0, 16'hBEEF);
    cyc(1, 0, 0, 16'h0FFF, 16'h0FFF, 0, 1, 16'h5A5A, 0, 0, 16'h5A5A);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h5A5A);

    // Halt suppresses access; stray mem_done in IDLE is ignored.
    cyc(1, 0, 1, 16'h0030, 16'h0000, 0, 1, 16'hFFFF, 0, 0, 16'h5A5A);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h1111, 0, 0, 16'h5A5A);

    // Misaligned read: error next cycle, later valid read blocked.
    cyc(1, 0, 0, 16'h0011, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h5A5A);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h5A5A);
    cyc(1, 0, 0, 16'h0040, 16'h0000, 0, 1, 16'h7777, 0, 1, 16'h5A5A);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h5A5A);
    do_reset();

    // Conflicting read+write.
    cyc(1, 1, 0, 16'h0050, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000);
    do_reset();

    // Timeout with TIMEOUT_CYCLES=4: four stall cycles, then error.
    exp_req(1'b0, 16'h0060, 16'h0000);
    cyc(1, 0, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000);
    cyc(1, 0, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000);
    cyc(1, 0, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000);
    cyc(1, 0, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000);
    cyc(1, 0, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000);
    do_reset();

    // Async reset mid-WAIT with the request still driven.
    exp_req(1'b0, 16'h0070, 16'h0000);
    cyc(1, 0, 0, 16'h0070, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000);
    cyc(1, 0, 0, 16'h0070, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_mem_en", 32'(mem_en), 32'(0));
    chk("arst_stall", 32'(stall_out), 32'(0));
    chk("arst_err", 32'(err_out), 32'(0));
    chk("arst_addr", 32'(mem_addr), 32'(0));
    chk("arst_rdata", 32'(rdata_out), 32'(0));
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    @(posedge clk);
    #2;
    chk("req_drained", 32'(req_q.size()), 32'(0));
    chk("cyc_drained", 32'(cyc_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Sequences the data-memory access for the instruction held in the EX/MEM pipeline register. It takes the EX/MEM control and data outputs, issues a single request to a multi-cycle data memory (busy/done handshake), and holds the pipeline with stall_out until the access completes. It also flags access errors (misaligned, conflicting control, timeout). It sits between the EX/MEM register outputs, the data memory, and the hazard/stall logic feeding the pipeline register enables.

Parameters:
TIMEOUT_CYCLES, 64, cycles spent in HOLD+WAIT before a timeout error is raised
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
MemRead_in  in  1  load request from EX/MEM
MemWrite_in  in  1  store request from EX/MEM
halt_in  in  1  halt instruction in EX/MEM; suppresses access
addr_in  in  16  effective address (ALU result)
wdata_in  in  16  store data
mem_stall  in  1  memory busy; cannot accept a request this cycle
mem_done  in  1  memory completes the outstanding access this cycle
mem_rdata  in  16  memory read data, valid when mem_done=1
mem_en  out  1  request strobe, one cycle per access
mem_wr  out  1  1=write, 0=read; valid with mem_en
mem_addr  out  16  request address
mem_wdata  out  16  request write data
rdata_out  out  16  load data to MEM/WB
stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
err_out  out  1  sticky access error

Behaviour:
- Reset (async, any state, including mid-access): state=IDLE; outstanding request dropped; all outputs 0; latches, timeout counter, rdata_q, and err cleared.
- Definitions: access = (MemRead_in|MemWrite_in) & ~halt_in & ~err_out. bad = access & (addr_in[0] | (MemRead_in & MemWrite_in)).
- bad in IDLE: no mem_en; err_out set next edge; stall_out=0.
- States: IDLE, HOLD, WAIT.
- IDLE, good access, mem_stall=0: combinationally drive mem_en=1, mem_wr=MemWrite_in, mem_addr=addr_in, mem_wdata=wdata_in.
  - If mem_done=1 in the same cycle: complete with zero stall; stay IDLE.
  - Otherwise: latch type/addr/wdata, go to WAIT, stall_out=1.
- IDLE, good access, mem_stall=1: latch type/addr/wdata, go to HOLD, stall_out=1, mem_en=0.
- HOLD: stall_out=1.
  - When mem_stall=0: issue the request from latched values (mem_en=1), then go to WAIT, or to IDLE if mem_done=1 in the same cycle.
- WAIT: mem_en=0, stall_out=1.
  - mem_done=1: completion; stall_out=0 that cycle; go to IDLE.
- Completion: if a read, rdata_out=mem_rdata combinationally and rdata_q<=mem_rdata. In all other cycles rdata_out=rdata_q.
- Exactly one mem_en per access. mem_addr/mem_wdata/mem_wr are 0 when mem_en=0.
- mem_done outside WAIT or an issuing cycle: ignored.
- Timeout counter: cleared on entry to HOLD/WAIT, increments each HOLD/WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without completion: err_out set, state goes to IDLE, stall_out=0 that cycle.
- err_out: sticky until rst. While set, no new requests are issued.
- The latched request is authoritative during HOLD/WAIT; changes on the inputs are ignored until return to IDLE.
- halt_in with MemRead/MemWrite: no access, no stall.

Optional Feature:
MEM_STAGE_PERF_CNT_EN:
- Defined: adds outputs acc_cnt[CNT_W-1:0] (increments on each completed access) and stall_cnt[CNT_W-1:0] (increments each cycle stall_out=1). Both counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters do not exist.

Test Plan:
- Read, addr=0x0010, mem_stall=0, mem_done same cycle, mem_rdata=0xBEEF -> one mem_en, mem_wr=0, stall_out never 1, rdata_out=0xBEEF, rdata_q=0xBEEF.
- Write, addr=0x0020, wdata=0x1234, mem_done 3 cycles after issue -> mem_en 1 cycle, stall_out=1 for 3 cycles then 0 on the done cycle, state back to IDLE.
- Read with mem_stall=1 for 2 cycles, then done 1 cycle after issue, inputs changed to 0x0FFF during HOLD -> mem_addr on issue = original 0x0010, single mem_en, stall 3 cycles.
- Read addr=0x0011 -> no mem_en, err_out=1 next cycle; a later valid read is not issued.
- TIMEOUT_CYCLES=4, mem_done never asserted -> stall_out=1 for 4 cycles, err_out=1, state IDLE; async rst mid-WAIT clears all outputs immediately.
- With MEM_STAGE_PERF_CNT_EN: run scenarios 1 and 2 back to back -> acc_cnt=2, stall_cnt=3.
